mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +---------------------------------------------------------------+
// | mem_arbiter_pkg : shared types for the fetch/data arbiter     |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------+
// | mem_arbiter : round-robin fetch/data arbiter onto one memory  |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_wsel,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_done,
  output logic            m_req,
  output logic            m_we,
  output logic [3:0]      m_wsel,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic [XLEN-1:0] m_rdata,
  input  logic            m_ack
);

  arb_state_t      r_state;
  arb_state_t      w_next_state;
  grant_t          w_grant;
  grant_t          r_grant;
  grant_t          r_last_grant;
  logic            r_we;
  logic [3:0]      r_wsel;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_i_rdata;
  logic [XLEN-1:0] r_d_rdata;
  logic            w_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // On a conflict the requester that did not win last time gets the memory.
  always_comb begin
    w_grant      = GRANT_I;
    w_next_state = r_state;
    if (d_req && (!i_req || r_last_grant == GRANT_I)) begin
      w_grant = GRANT_D;
    end
    case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_next_state = (w_grant == GRANT_D) ? DBUSY : IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (m_ack) begin
          w_next_state = RESP;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant      <= GRANT_I;
      r_last_grant <= GRANT_I;
      r_we         <= 1'b0;
      r_wsel       <= 4'b0000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      if (r_state == IDLE && (i_req || d_req)) begin
        r_grant <= w_grant;
        if (w_grant == GRANT_D) begin
          r_we    <= d_we;
          r_wsel  <= d_wsel;
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
        end else begin
          r_we    <= 1'b0;
          r_wsel  <= 4'b0000;
          r_addr  <= i_addr;
          r_wdata <= '0;
        end
      end
      if (w_busy && m_ack) begin
        r_last_grant <= r_grant;
        if (r_grant == GRANT_D) begin
          r_d_rdata <= m_rdata;
        end else begin
          r_i_rdata <= m_rdata;
        end
      end
    end
  end

  always_comb begin
    w_busy  = (r_state == IBUSY) || (r_state == DBUSY);
    m_req   = w_busy;
    m_we    = w_busy && r_we;
    m_wsel  = w_busy ? r_wsel : 4'b0000;
    m_addr  = r_addr;
    m_wdata = r_wdata;
    i_done  = (r_state == RESP) && (r_grant == GRANT_I);
    d_done  = (r_state == RESP) && (r_grant == GRANT_D);
  end

  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench for mem_arbiter             |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_wsel = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_wsel;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;

  mem_arbiter #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_wsel(d_wsel), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_we(m_we), .m_wsel(m_wsel), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  wsel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
  } resp_exp_t;

  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];
  mem_exp_t  me;
  resp_exp_t re;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_d, input bit we, input logic [3:0] wsel,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata);
    exp_mem.push_back('{we: we, wsel: wsel, addr: addr, wdata: wdata});
    exp_resp.push_back('{is_d: is_d, rdata: rdata});
  endtask

  // Wait for the grant, hold ack low for 'waits' cycles, then ack and check the done pulse.
  task automatic serve(input bit is_d, input logic [31:0] addr, input logic [31:0] rdata,
                       input int waits, input int exp_lat);
    int lat;
    lat = 0;
    while (!m_req && lat < 20) begin
      tick();
      lat++;
    end
    check("req_latency", lat, exp_lat);
    for (int k = 0; k < waits; k++) begin
      check("hold_m_req", {31'b0, m_req}, 32'd1);
      check("hold_m_addr", m_addr, addr);
      check("hold_no_done", {31'b0, i_done | d_done}, 32'd0);
      tick();
    end
    m_ack   = 1'b1;
    m_rdata = rdata;
    tick();
    m_ack   = 1'b0;
    m_rdata = 32'hBAD0_BAD0;
    check(is_d ? "d_done_pulse" : "i_done_pulse", {31'b0, is_d ? d_done : i_done}, 32'd1);
    check("other_done_low", {31'b0, is_d ? i_done : d_done}, 32'd0);
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (m_req && m_ack) begin
        if (exp_mem.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_unexpected: got addr 0x%08h expected no transaction", m_addr);
        end else begin
          me = exp_mem.pop_front();
          check("m_addr", m_addr, me.addr);
          check("m_we", {31'b0, m_we}, {31'b0, me.we});
          check("m_wsel", {28'b0, m_wsel}, {28'b0, me.wsel});
          check("m_wdata", m_wdata, me.wdata);
        end
      end
      if (i_done || d_done) begin
        check("done_exclusive", {31'b0, i_done & d_done}, 32'd0);
        if (exp_resp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: got i_done=%0b d_done=%0b expected none", i_done, d_done);
        end else begin
          re = exp_resp.pop_front();
          check("done_owner", {31'b0, d_done}, {31'b0, re.is_d});
          check("rdata", re.is_d ? d_rdata : i_rdata, re.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tick(); tick(); tick();
    reset = 1'b0;
    check("reset_m_ctrl", {26'b0, m_req, m_we, m_wsel}, 32'd0);
    check("reset_m_addr", m_addr, 32'd0);
    check("reset_m_wdata", m_wdata, 32'd0);
    check("reset_i_rdata", i_rdata, 32'd0);
    check("reset_d_rdata", d_rdata, 32'd0);
    check("reset_done", {30'b0, i_done, d_done}, 32'd0);

    // Conflict out of reset: data first, then fetch, then data wins the next conflict.
    i_addr = 32'h200; d_we = 1'b0; d_wsel = 4'b0000; d_addr = 32'h400; d_wdata = '0;
    push(1'b1, 1'b0, 4'b0000, 32'h400, 32'h0, 32'h1111_1111);
    push(1'b0, 1'b0, 4'b0000, 32'h200, 32'h0, 32'h2222_2222);
    i_req = 1'b1; d_req = 1'b1;
    serve(1'b1, 32'h400, 32'h1111_1111, 0, 1);
    serve(1'b0, 32'h200, 32'h2222_2222, 0, 1);
    i_addr = 32'h204; d_addr = 32'h404;
    push(1'b1, 1'b0, 4'b0000, 32'h404, 32'h0, 32'h3333_3333);
    push(1'b0, 1'b0, 4'b0000, 32'h204, 32'h0, 32'h4444_4444);
    i_req = 1'b1; d_req = 1'b1;
    serve(1'b1, 32'h404, 32'h3333_3333, 0, 1);
    serve(1'b0, 32'h204, 32'h4444_4444, 0, 1);

    // Fetch with one wait cycle: done lands three cycles after the request.
    i_addr = 32'h100;
    push(1'b0, 1'b0, 4'b0000, 32'h100, 32'h0, 32'h0050_0093);
    i_req = 1'b1;
    serve(1'b0, 32'h100, 32'h0050_0093, 1, 1);

    // Zero-wait store.
    d_we = 1'b1; d_wsel = 4'b1111; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF;
    push(1'b1, 1'b1, 4'b1111, 32'h2004, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    d_req = 1'b1;
    serve(1'b1, 32'h2004, 32'h0BAD_F00D, 0, 1);

    // Fetch stalled five cycles; d_rdata must keep the store's captured value.
    i_addr = 32'h104;
    push(1'b0, 1'b0, 4'b0000, 32'h104, 32'h0, 32'hCAFE_F00D);
    i_req = 1'b1;
    serve(1'b0, 32'h104, 32'hCAFE_F00D, 5, 1);
    check("d_rdata_hold", d_rdata, 32'h0BAD_F00D);

    // Load whose requester drops d_req mid-transaction.
    d_we = 1'b0; d_wsel = 4'b0000; d_addr = 32'h3008; d_wdata = '0;
    push(1'b1, 1'b0, 4'b0000, 32'h3008, 32'h0, 32'h1234_5678);
    d_req = 1'b1;
    tick();
    d_req = 1'b0;
    serve(1'b1, 32'h3008, 32'h1234_5678, 0, 0);
    check("d_rdata_drop", d_rdata, 32'h1234_5678);

    // Stray ack while idle.
    m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    m_ack = 1'b0;
    check("idle_ack_m_req", {31'b0, m_req}, 32'd0);
    check("idle_ack_i_rdata", i_rdata, 32'hCAFE_F00D);

    // Reset during a store abandons it.
    d_we = 1'b1; d_wsel = 4'b0011; d_addr = 32'h5000; d_wdata = 32'h0000_A5A5;
    d_req = 1'b1;
    tick();
    check("pre_reset_m_req", {31'b0, m_req}, 32'd1);
    check("pre_reset_m_wsel", {28'b0, m_wsel}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_req = 1'b0;
    check("rst_busy_m_ctrl", {26'b0, m_req, m_we, m_wsel}, 32'd0);
    check("rst_busy_m_addr", m_addr, 32'd0);
    check("rst_busy_m_wdata", m_wdata, 32'd0);
    check("rst_busy_rdata", i_rdata | d_rdata, 32'd0);
    check("rst_busy_done", {30'b0, i_done, d_done}, 32'd0);
    repeat (4) tick();

    check("exp_mem_drained", exp_mem.size(), 32'd0);
    check("exp_resp_drained", exp_resp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
